// File: rtl/obi_pkg.sv
// Shared types and helpers for the Wishbone-to-OBI bridge.
//   bridge_state_e : bridge FSM states
//   obi_aph_t      : registered OBI address phase (addr, we, be, wdata)
//   be_width()     : byte-enable width for a given data width
//   timer_width()  : counter width able to hold a given timeout value
package obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int timer_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

  localparam int OBI_BE_W = be_width(OBI_DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    ACK,
    DRAIN
  } bridge_state_e;

  // Address-phase fields are sized for the Caravel user bus; the bridge
  // width parameters default to these and are expected to match them.
  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_aph_t;

endpackage

// File: rtl/obi_timeout_ctr.sv
// Timeout up-counter for the bridge.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : restart the count from zero (wins over i_en)
//   i_en           : count this cycle
//   o_expired      : high in the enabled cycle in which the count reaches
//                    TIMEOUT_CYCLES; tied low when TIMEOUT_CYCLES = 0
module obi_timeout_ctr
  import obi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    localparam int               CNT_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + 1'b1;
    assign o_expired   = i_en && (w_count_inc == LIMIT);

    // NOTE: reset is sampled only at the clock edge (synchronous), and all
    // clocked state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_count <= '0;
      end else if (i_clr) begin
        r_count <= '0;
      end else if (i_en && !o_expired) begin
        r_count <= w_count_inc;
      end
    end
  end else begin : g_no_timer
    logic w_unused;
    assign w_unused  = ^{i_clk, i_rst_n, i_clr, i_en};
    assign o_expired = 1'b0;
  end

endmodule

// File: rtl/wb_to_obi_bridge.sv
// Wishbone-classic slave to OBI master bridge, one transaction at a time.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   wbs_*_i / wbs_*_o      : WB slave side; ack/err are one-cycle pulses,
//                            wbs_dat_o is the registered read data
//   req_o, gnt_i           : OBI address-phase handshake
//   addr_o/we_o/be_o/wdata_o : registered OBI address phase
//   rvalid_i/rdata_i/err_i : OBI response phase
//   busy_o                 : high whenever the FSM is not in IDLE
//   timeout_o              : one-cycle pulse when the timer fires
module wb_to_obi_bridge
  import obi_pkg::*;
#(
  parameter int       ADDR_W         = OBI_ADDR_W,
  parameter int       DATA_W         = OBI_DATA_W,
  parameter int       TIMEOUT_CYCLES = 256,
  parameter bit       ERR_EN         = 1'b1,
  localparam int      BE_W           = be_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [BE_W-1:0]   wbs_sel_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              err_i,
  output logic              busy_o,
  output logic              timeout_o
);

  bridge_state_e     r_state;
  bridge_state_e     w_state_next;
  obi_aph_t          r_aph;
  logic [DATA_W-1:0] r_rdata;
  logic              r_abort;     // WB master left the cycle; suppress response
  logic              r_err;       // captured err_i or forced timeout error
  logic              r_timeout;
  logic              r_to_drain;  // RESP timed out: a late rvalid must be eaten

  logic w_accept;
  logic w_fire;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_expired;
  logic w_resp;
  logic w_resp_err;

  assign w_accept   = (r_state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign w_timer_en = (r_state == REQ) || (r_state == RESP) || (r_state == DRAIN);

  obi_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expired(w_expired)
  );

  // Handshake events are tested before the timer so that a grant or a
  // response arriving in the expiry cycle still completes normally.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_timer_clr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = REQ;
          w_timer_clr  = 1'b1;
        end
      end
      REQ: begin
        if (gnt_i) begin
          w_state_next = RESP;
          w_timer_clr  = 1'b1;
        end else if (w_expired) begin
          w_state_next = ACK;
          w_fire       = 1'b1;
          w_timer_clr  = 1'b1;
        end
      end
      RESP: begin
        if (rvalid_i) begin
          w_state_next = ACK;
        end else if (w_expired) begin
          w_state_next = ACK;
          w_fire       = 1'b1;
          w_timer_clr  = 1'b1;  // DRAIN gets a fresh timeout window
        end
      end
      ACK: begin
        w_state_next = r_to_drain ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (rvalid_i) begin
          w_state_next = IDLE;
        end else if (w_expired) begin
          w_state_next = IDLE;
          w_fire       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_aph      <= '0;
      r_rdata    <= '0;
      r_abort    <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_to_drain <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timeout <= w_fire;

      if (w_accept) begin
        r_aph.addr  <= wbs_adr_i;
        r_aph.we    <= wbs_we_i;
        r_aph.be    <= wbs_sel_i;
        r_aph.wdata <= wbs_dat_i;
        r_abort     <= 1'b0;
        r_err       <= 1'b0;
        r_to_drain  <= 1'b0;
      end

      // The OBI side always finishes; only the WB response is dropped.
      if (((r_state == REQ) || (r_state == RESP)) && !wbs_cyc_i) begin
        r_abort <= 1'b1;
      end

      if ((r_state == RESP) && rvalid_i) begin
        r_err <= err_i;
        if (!r_aph.we) begin
          r_rdata <= rdata_i;
        end
      end else if (w_fire && (r_state != DRAIN)) begin
        r_err      <= 1'b1;
        r_to_drain <= (r_state == RESP);
        // Without error signalling a timed-out read is acked with zero data.
        if (!ERR_EN && !r_aph.we) begin
          r_rdata <= '0;
        end
      end
    end
  end

  assign w_resp     = (r_state == ACK) && !r_abort;
  assign w_resp_err = r_err && ERR_EN;

  assign wbs_ack_o = w_resp && !w_resp_err;
  assign wbs_err_o = w_resp && w_resp_err;
  assign wbs_dat_o = r_rdata;
  assign req_o     = (r_state == REQ);
  assign addr_o    = r_aph.addr;
  assign we_o      = r_aph.we;
  assign be_o      = r_aph.be;
  assign wdata_o   = r_aph.wdata;
  assign busy_o    = (r_state != IDLE);
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_to_obi_bridge.sv
// Self-checking bench for wb_to_obi_bridge. Two instances share stimulus:
// u_dut (ERR_EN=1) and u_dut_ne (ERR_EN=0), both with an 8-cycle timeout.
// Expected WB responses of u_dut are queued when a request is issued and
// popped by a monitor whenever u_dut raises ack or err.
module tb_wb_to_obi_bridge;

  logic        clk;
  logic        rst_n;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  logic        wbs_ack_o, wbs_err_o, req_o, we_o, busy_o, timeout_o;
  logic [31:0] wbs_dat_o, addr_o, wdata_o;
  logic [3:0]  be_o;

  logic        ne_ack, ne_err, ne_req, ne_we, ne_busy, ne_to;
  logic [31:0] ne_dat, ne_addr, ne_wdata;
  logic [3:0]  ne_be;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  wb_to_obi_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_EN        (1'b1)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_err_o(wbs_err_o),
    .wbs_dat_o(wbs_dat_o),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .addr_o   (addr_o),
    .we_o     (we_o),
    .be_o     (be_o),
    .wdata_o  (wdata_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .err_i    (err_i),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  wb_to_obi_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_EN        (1'b0)
  ) u_dut_ne (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(ne_ack),
    .wbs_err_o(ne_err),
    .wbs_dat_o(ne_dat),
    .req_o    (ne_req),
    .gnt_i    (gnt_i),
    .addr_o   (ne_addr),
    .we_o     (ne_we),
    .be_o     (ne_be),
    .wdata_o  (ne_wdata),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .err_i    (err_i),
    .busy_o   (ne_busy),
    .timeout_o(ne_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sb_push(input logic is_err, input logic [31:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Response monitor: every ack/err from u_dut must match the queue head.
  always @(negedge clk) begin
    if (rst_n && (wbs_ack_o || wbs_err_o)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", {wbs_ack_o, wbs_err_o}, 2'b00);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_kind", {wbs_ack_o, wbs_err_o}, sb_e.is_err ? 2'b01 : 2'b10);
        check("sb_data", wbs_dat_o, sb_e.data);
      end
    end
  end

  task automatic check_reset_state();
    check("rst_req", req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_resp", {wbs_ack_o, wbs_err_o}, 0);
    check("rst_addr", addr_o, 0);
    check("rst_we", we_o, 0);
    check("rst_be", be_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_ne_busy", ne_busy, 0);
    check("rst_ne_dat", ne_dat, 0);
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] wdat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_sel_i = sel;
    wbs_dat_i = wdat;
  endtask

  task automatic drop_req();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  // Full WB transaction: grant in the (gnt_dly+1)-th REQ cycle, response in
  // the (rv_dly+1)-th RESP cycle, WB response expected in the next cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdat, input logic oerr,
                         input logic exp_err, input logic [31:0] exp_dat);
    sb_push(exp_err, exp_dat);
    drive_req(we, adr, sel, wdat);
    tick();
    for (int i = 0; i <= gnt_dly; i++) begin
      check("req_hold", req_o, 1);
      check("addr_stable", addr_o, adr);
      check("be_stable", be_o, sel);
      check("we_stable", we_o, we);
      if (we) check("wdata_stable", wdata_o, wdat);
      if (i == gnt_dly) gnt_i = 1'b1;
      tick();
    end
    gnt_i = 1'b0;
    for (int i = 0; i <= rv_dly; i++) begin
      check("req_dropped", req_o, 0);
      check("no_early_resp", {wbs_ack_o, wbs_err_o}, 0);
      if (i == rv_dly) begin
        rvalid_i = 1'b1;
        rdata_i  = rdat;
        err_i    = oerr;
      end
      tick();
    end
    rvalid_i = 1'b0;
    err_i    = 1'b0;
    rdata_i  = '0;
    check("resp_cycle", {wbs_ack_o, wbs_err_o}, exp_err ? 2'b01 : 2'b10);
    check("resp_no_timeout", timeout_o, 0);
    check("ne_resp_ack", {ne_ack, ne_err}, 2'b10);
    if (!we) check("ne_rdata", ne_dat, rdat);
    drop_req();
    tick();
    check("busy_after", busy_o, 0);
    check("single_pulse", {wbs_ack_o, wbs_err_o}, 0);
  endtask

  // Read granted at once, never answered: forced error, then DRAIN.
  task automatic resp_timeout(input logic [31:0] adr, input logic [31:0] exp_dat);
    sb_push(1'b1, exp_dat);
    drive_req(1'b0, adr, 4'hf, 32'h0);
    tick();
    check("to_req", req_o, 1);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to_wait_pulse", timeout_o, 0);
      check("to_wait_resp", {wbs_ack_o, wbs_err_o}, 0);
      tick();
    end
    check("to_pulse", timeout_o, 1);
    check("to_err", {wbs_ack_o, wbs_err_o}, 2'b01);
    check("to_ne_ack", {ne_ack, ne_err}, 2'b10);
    check("to_ne_dat", ne_dat, 0);
    drop_req();
    tick();
    check("to_pulse_single", timeout_o, 0);
    check("drain_busy", busy_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = '0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    gnt_i     = 1'b0;
    rvalid_i  = 1'b0;
    rdata_i   = '0;
    err_i     = 1'b0;

    tick();
    tick();
    check_reset_state();
    rst_n = 1'b1;
    tick();

    // Zero-wait read: req in cycle 1 only, ack in cycle 3.
    wb_xfer(1'b0, 32'h3000_0010, 4'hf, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // Write with a 4-cycle grant stall; read data register untouched.
    wb_xfer(1'b1, 32'h3000_0020, 4'b0101, 32'h1234_5678, 4, 0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // OBI error on a read: err here, ack on the ERR_EN=0 instance.
    wb_xfer(1'b0, 32'h3000_0024, 4'hf, 32'h0, 0, 1, 32'hBAD0_0001, 1'b1, 1'b1, 32'hBAD0_0001);

    // Grant in the expiry cycle of REQ wins over the timeout.
    wb_xfer(1'b0, 32'h3000_0028, 4'hf, 32'h0, 7, 0, 32'h1111_2222, 1'b0, 1'b0, 32'h1111_2222);

    // rvalid in the expiry cycle of RESP wins over the timeout.
    wb_xfer(1'b0, 32'h3000_002c, 4'hf, 32'h0, 0, 7, 32'h3333_4444, 1'b0, 1'b0, 32'h3333_4444);

    // Timeout in REQ: req dropped, forced error, straight back to IDLE.
    sb_push(1'b1, 32'h3333_4444);
    drive_req(1'b0, 32'h3000_0030, 4'hf, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("req_to_hold", req_o, 1);
      check("req_to_pulse_low", timeout_o, 0);
      tick();
    end
    check("req_to_retract", req_o, 0);
    check("req_to_pulse", timeout_o, 1);
    check("req_to_err", {wbs_ack_o, wbs_err_o}, 2'b01);
    check("req_to_ne_ack", {ne_ack, ne_err}, 2'b10);
    check("req_to_ne_dat", ne_dat, 0);
    drop_req();
    tick();
    check("req_to_idle", busy_o, 0);
    check("req_to_pulse_single", timeout_o, 0);

    // Timeout in RESP; a new request is held off in DRAIN, the late
    // response is discarded, and the next read completes normally.
    resp_timeout(32'h3000_0034, 32'h3333_4444);
    drive_req(1'b0, 32'h3000_0040, 4'hf, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("drain_no_req", req_o, 0);
      check("drain_busy_hold", busy_o, 1);
      tick();
    end
    rvalid_i = 1'b1;
    rdata_i  = 32'h5555_AAAA;
    tick();
    rvalid_i = 1'b0;
    rdata_i  = '0;
    check("drain_exit_idle", busy_o, 0);
    check("drain_exit_no_req", req_o, 0);
    check("drain_discard_resp", {wbs_ack_o, wbs_err_o}, 0);
    check("drain_discard_dat", wbs_dat_o, 32'h3333_4444);
    wb_xfer(1'b0, 32'h3000_0040, 4'hf, 32'h0, 0, 0, 32'h7777_8888, 1'b0, 1'b0, 32'h7777_8888);

    // Timeout in RESP followed by a second timeout in DRAIN.
    resp_timeout(32'h3000_0080, 32'h7777_8888);
    for (int i = 0; i < 8; i++) begin
      check("drain_to_busy", busy_o, 1);
      check("drain_to_pulse_low", timeout_o, 0);
      tick();
    end
    check("drain_to_idle", busy_o, 0);
    check("drain_to_pulse", timeout_o, 1);
    check("drain_to_no_resp", {wbs_ack_o, wbs_err_o}, 0);
    tick();
    check("drain_to_pulse_single", timeout_o, 0);

    // Abort: cyc dropped in REQ; OBI completes, no WB response.
    drive_req(1'b1, 32'h3000_0050, 4'hc, 32'hA5A5_A5A5);
    tick();
    drop_req();
    for (int i = 0; i < 3; i++) begin
      check("abort_req_held", req_o, 1);
      check("abort_addr_held", addr_o, 32'h3000_0050);
      tick();
    end
    gnt_i = 1'b1;
    tick();
    gnt_i    = 1'b0;
    rvalid_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    check("abort_no_resp", {wbs_ack_o, wbs_err_o}, 0);
    check("abort_ne_no_resp", {ne_ack, ne_err}, 0);
    check("abort_busy_ack", busy_o, 1);
    tick();
    check("abort_idle", busy_o, 0);
    check("abort_dat_kept", wbs_dat_o, 32'h7777_8888);

    // Reset in RESP: everything returns to zero, then a write works.
    drive_req(1'b0, 32'h3000_0060, 4'hf, 32'h0);
    tick();
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    drop_req();
    rst_n = 1'b0;
    tick();
    check_reset_state();
    rst_n = 1'b1;
    wb_xfer(1'b1, 32'h3000_0070, 4'b0011, 32'hCAFE_F00D, 1, 1, 32'h0, 1'b0, 1'b0, 32'h0);

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
